// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared widths and controller state encoding for the AES-128
//                round controller slice.
//  Revision    : 1.0
// ============================================================================
package aes_pkg;

    localparam int NR      = 10;
    localparam int KEY_W   = 128;
    localparam int SCHED_W = 1408;
    localparam int RIDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEXP  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/aes_rk_mux.sv
`default_nettype none
// ============================================================================
//  Module      : aes_rk_mux
//  Description : Selects the 128-bit round key for round_idx from the packed
//                key schedule; indices beyond the last round give zero.
//  Revision    : 1.0
// ============================================================================
module aes_rk_mux
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic [SCHED_W-1:0] ke_schedule,
    input  logic [RIDX_W-1:0]  round_idx,
    output logic [KEY_W-1:0]   rk
);

    always_comb begin
        rk = '0;
        for (int i = 0; i <= NR; i++) begin
            if (round_idx == RIDX_W'(i)) begin
                rk = ke_schedule[KEY_W*i +: KEY_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl
//  Description : Sequences key expansion and the 11 round steps of one AES-128
//                encryption, with valid/ready handshakes on both block sides.
//  Revision    : 1.0
// ============================================================================
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR         = 10,
    parameter int KE_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_load,
    output logic               ke_start,
    input  logic               ke_finish,
    input  logic [SCHED_W-1:0] ke_schedule,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               rnd_load,
    output logic               rnd_en,
    output logic               rnd_final,
    output logic [RIDX_W-1:0]  round_idx,
    output logic [KEY_W-1:0]   rk,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               key_valid,
    output logic               busy,
    output logic               err
);

    localparam int CNT_W = $clog2(KE_TIMEOUT + 1);

    state_e             state_q,     state_d;
    logic [RIDX_W-1:0]  round_idx_q, round_idx_d;
    logic               key_valid_q, key_valid_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               err_q,       err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            round_idx_q <= '0;
            key_valid_q <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_idx_q <= round_idx_d;
            key_valid_q <= key_valid_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        round_idx_d = round_idx_q;
        key_valid_d = key_valid_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        ke_start    = 1'b0;
        in_ready    = 1'b0;
        rnd_load    = 1'b0;
        rnd_en      = 1'b0;
        rnd_final   = 1'b0;
        out_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = key_valid_q & ~key_load;
                if (key_load) begin
                    state_d     = KEXP;
                    key_valid_d = 1'b0;
                    cnt_d       = '0;
                end else if (in_valid && in_ready) begin
                    rnd_load    = 1'b1;
                    state_d     = ROUND;
                    round_idx_d = RIDX_W'(1);
                end
            end
            KEXP: begin
                ke_start = (cnt_q == '0);
                cnt_d    = cnt_q + CNT_W'(1);
                err_d    = key_load;
                // The engine still shows the previous finish level on its start cycle.
                if (ke_finish && (cnt_q != '0)) begin
                    key_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_W'(KE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            ROUND: begin
                rnd_en    = 1'b1;
                rnd_final = (round_idx_q == RIDX_W'(NR));
                err_d     = key_load;
                if (rnd_final) begin
                    state_d = DONE;
                end else begin
                    round_idx_d = round_idx_q + RIDX_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                err_d     = key_load;
                if (out_ready) begin
                    state_d     = IDLE;
                    round_idx_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    aes_rk_mux #(
        .NR (NR)
    ) u_rk_mux (
        .ke_schedule (ke_schedule),
        .round_idx   (round_idx_q),
        .rk          (rk)
    );

    assign round_idx = round_idx_q;
    assign key_valid = key_valid_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_ctrl
//  Description : Directed, table-driven bench for aes_round_ctrl with a
//                keyexpansion stub and the FIPS-197 key 000102..0f schedule.
//  Revision    : 1.0
// ============================================================================
module tb_aes_round_ctrl;
    import aes_pkg::*;

    logic               clk = 1'b0;
    logic               rst, key_load, ke_start, ke_finish, in_valid, in_ready;
    logic               rnd_load, rnd_en, rnd_final, out_valid, out_ready;
    logic               key_valid, busy, err, stub_en;
    logic [SCHED_W-1:0] ke_schedule;
    logic [RIDX_W-1:0]  round_idx;
    logic [KEY_W-1:0]   rk;
    logic [127:0]       fips_rk [0:10];
    int                 stub_cnt;
    int                 checks = 0;
    int                 errors = 0;

    typedef struct {
        logic [3:0] idx;
        logic       ld, en, fin, ov;
    } rvec_t;
    rvec_t tbl [0:11];

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10), .KE_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .ke_start(ke_start),
        .ke_finish(ke_finish), .ke_schedule(ke_schedule), .in_valid(in_valid),
        .in_ready(in_ready), .rnd_load(rnd_load), .rnd_en(rnd_en),
        .rnd_final(rnd_final), .round_idx(round_idx), .rk(rk),
        .out_valid(out_valid), .out_ready(out_ready), .key_valid(key_valid),
        .busy(busy), .err(err)
    );

    // Keyexpansion stub: drops finish on start, raises it 44 cycles later when enabled.
    always @(posedge clk) begin
        if (rst) begin
            ke_finish <= 1'b0;
            stub_cnt  <= 0;
        end else if (ke_start) begin
            ke_finish <= 1'b0;
            stub_cnt  <= 1;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == 43) begin
                ke_finish <= stub_en;
                stub_cnt  <= 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bus packs word w[i] at [32i+:32], so round key r reads back word-reversed.
    function automatic logic [127:0] exp_rk(input logic [3:0] r);
        logic [127:0] f;
        f = fips_rk[r];
        return {f[31:0], f[63:32], f[95:64], f[127:96]};
    endfunction

    task automatic run_block(input int kl_at);
        for (int k = 0; k < 12; k++) begin
            in_valid = (k == 0);
            key_load = (k == kl_at);
            #1;
            chk($sformatf("round_idx_k%0d", k), round_idx, tbl[k].idx);
            chk($sformatf("rnd_load_k%0d", k),  rnd_load,  tbl[k].ld);
            chk($sformatf("rnd_en_k%0d", k),    rnd_en,    tbl[k].en);
            chk($sformatf("rnd_final_k%0d", k), rnd_final, tbl[k].fin);
            chk($sformatf("out_valid_k%0d", k), out_valid, tbl[k].ov);
            chk($sformatf("rk_k%0d", k),        rk,        exp_rk(tbl[k].idx));
            chk($sformatf("key_valid_k%0d", k), key_valid, 1'b1);
            if (kl_at >= 0 && k == kl_at + 1) chk("err_on_key_load_in_round", err, 1'b1);
            cyc();
        end
        in_valid = 1'b0;
        key_load = 1'b0;
    endtask

    task automatic kexp_watch(input int kl_at, output int end_off, output int starts,
                              output int errs, output int err_off);
        end_off = -1; starts = 0; errs = 0; err_off = -1;
        for (int n = 0; n < 150; n++) begin
            key_load = (n == kl_at);
            #1;
            if (ke_start) starts++;
            if (err) begin
                errs++;
                err_off = n;
            end
            if (n > 0 && !busy) begin
                end_off = n;
                break;
            end
            cyc();
        end
        key_load = 1'b0;
    endtask

    initial begin
        int end_off, starts, errs, err_off;

        fips_rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        fips_rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        fips_rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        fips_rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        fips_rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        fips_rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        fips_rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        fips_rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        fips_rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        fips_rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        fips_rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        for (int r = 0; r <= 10; r++)
            for (int j = 0; j < 4; j++)
                ke_schedule[32*(4*r+j) +: 32] = fips_rk[r][127-32*j -: 32];

        //          idx    ld    en    fin   ov
        tbl[0]  = '{4'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4'd1,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'd2,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{4'd3,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{4'd4,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{4'd5,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{4'd6,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{4'd7,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{4'd8,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{4'd9,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{4'd10, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{4'd10, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stub_en = 1'b1;
        cyc(); cyc();
        chk("rst_round_idx", round_idx, 4'd0);
        chk("rst_key_valid", key_valid, 1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_ke_start",  ke_start,  1'b0);
        chk("rst_err",       err,       1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_rnd_en",    rnd_en,    1'b0);
        chk("idle_rk0",      rk,        exp_rk(4'd0));
        rst = 1'b0;
        cyc();

        // Key expansion with the stub finishing 44 cycles after start.
        key_load = 1'b1;
        #1;
        chk("kl_in_ready", in_ready, 1'b0);
        cyc();
        key_load = 1'b0;
        kexp_watch(-1, end_off, starts, errs, err_off);
        chk("kexp_end_offset", end_off, 45);
        chk("kexp_ke_start_pulses", starts, 1);
        chk("kexp_err_count", errs, 0);
        chk("kexp_key_valid", key_valid, 1'b1);
        chk("kexp_in_ready", in_ready, 1'b1);

        // First block, then hold the result for 5 cycles in DONE.
        chk("rk0_const", exp_rk(4'd0), 128'h0c0d0e0f08090a0b0405060700010203);
        run_block(-1);
        for (int h = 0; h < 4; h++) begin
            #1;
            chk($sformatf("hold_out_valid_%0d", h), out_valid, 1'b1);
            chk($sformatf("hold_in_ready_%0d", h),  in_ready,  1'b0);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("handshake_out_valid", out_valid, 1'b1);
        chk("handshake_rk10", rk, 128'h4d2b30c5f307a78be3944a1713111d7f);
        cyc();
        out_ready = 1'b0;
        chk("post_hs_busy", busy, 1'b0);
        chk("post_hs_round_idx", round_idx, 4'd0);

        // Second block starts immediately; key_load at round 5 must be rejected.
        run_block(5);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // key_load together with in_valid in IDLE; key_load again mid-expansion.
        key_load = 1'b1; in_valid = 1'b1;
        #1;
        chk("kl_iv_in_ready", in_ready, 1'b0);
        chk("kl_iv_rnd_load", rnd_load, 1'b0);
        cyc();
        key_load = 1'b0; in_valid = 1'b0;
        chk("kl_iv_key_valid", key_valid, 1'b0);
        kexp_watch(2, end_off, starts, errs, err_off);
        chk("kexp2_end_offset", end_off, 45);
        chk("kexp2_ke_start_pulses", starts, 1);
        chk("kexp2_err_count", errs, 1);
        chk("kexp2_err_offset", err_off, 3);
        chk("kexp2_key_valid", key_valid, 1'b1);

        // Reset during round 4.
        in_valid = 1'b1;
        #1;
        chk("rst_blk_rnd_load", rnd_load, 1'b1);
        cyc();
        in_valid = 1'b0;
        cyc(); cyc(); cyc();
        chk("rst_blk_round4", round_idx, 4'd4);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_round_idx", round_idx, 4'd0);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_key_valid", key_valid, 1'b0);
        chk("midrst_busy",      busy,      1'b0);

        // Stub never finishes: expansion times out.
        stub_en = 1'b0;
        key_load = 1'b1;
        #1;
        cyc();
        key_load = 1'b0;
        kexp_watch(-1, end_off, starts, errs, err_off);
        chk("tmo_end_offset", end_off, 64);
        chk("tmo_err_count", errs, 1);
        chk("tmo_err_offset", err_off, 64);
        chk("tmo_key_valid", key_valid, 1'b0);
        cyc();
        chk("tmo_err_single", err, 1'b0);
        chk("tmo_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
